// File: rtl/conj_vxc_pkg.sv
// Shared types and helpers for the conj(c)*conj(v) add/sub datapath.
// Optional build macro: CONJ_VXC_SAT_EN (saturate instead of wrap).
package conj_vxc_pkg;

  localparam int EW     = 64;
  localparam int COMP_W = 32;
  localparam int FRAC_W = 16;
  localparam int LAT    = 3;

  typedef struct packed {
    logic signed [COMP_W-1:0] re;
    logic signed [COMP_W-1:0] im;
  } cplx_t;

  localparam logic [COMP_W-1:0] C_MIN = {1'b1, {(COMP_W-1){1'b0}}};
  localparam logic [COMP_W-1:0] C_MAX = {1'b0, {(COMP_W-1){1'b1}}};

  // Q32.32 sum -> Q16.16 (floor), wrap or clamp to 32 bits
  function automatic logic signed [COMP_W-1:0] rescale(
    input logic signed [2*COMP_W:0] s
  );
`ifdef CONJ_VXC_SAT_EN
    logic signed [2*COMP_W:0] sh;
    sh = s >>> FRAC_W;
    if (sh[2*COMP_W:COMP_W-1] != {(COMP_W+2){sh[2*COMP_W]}})
      return sh[2*COMP_W] ? C_MIN : C_MAX;
    return sh[COMP_W-1:0];
`else
    return COMP_W'(s >>> FRAC_W);
`endif
  endfunction

  // Final 32-bit add/sub of the product onto the addend
  function automatic logic signed [COMP_W-1:0] addsub(
    input logic signed [COMP_W-1:0] a,
    input logic signed [COMP_W-1:0] p,
    input logic                     sub
  );
`ifdef CONJ_VXC_SAT_EN
    logic [COMP_W:0] r;
    r = sub ? ({a[COMP_W-1], a} - {p[COMP_W-1], p})
            : ({a[COMP_W-1], a} + {p[COMP_W-1], p});
    if (r[COMP_W] != r[COMP_W-1])
      return r[COMP_W] ? C_MIN : C_MAX;
    return r[COMP_W-1:0];
`else
    return sub ? a - p : a + p;
`endif
  endfunction

endpackage

// File: rtl/conj_vxc_addsub_pipe_conj_cmul_lane.sv
// One lane of conj(c)*conj(v) = conj(c*v) with its stage-2 register.
// Rescale/saturation follows CONJ_VXC_SAT_EN through the package helper.
module conj_cmul_lane
  import conj_vxc_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  cplx_t c,
  input  cplx_t v,
  output cplx_t p
);

  logic signed [2*COMP_W-1:0] ax, by, ay, bx;
  logic        [2*COMP_W:0]   s_re, s_im;

  // Full-precision products; imag part is negated for the conjugate
  always_comb begin
    ax   = $signed(c.re) * $signed(v.re);
    by   = $signed(c.im) * $signed(v.im);
    ay   = $signed(c.re) * $signed(v.im);
    bx   = $signed(c.im) * $signed(v.re);
    s_re = {ax[2*COMP_W-1], ax} - {by[2*COMP_W-1], by};
    s_im = -({ay[2*COMP_W-1], ay} + {bx[2*COMP_W-1], bx});
  end

  // Stage 2: rescaled product register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p <= '0;
    end else begin
      p.re <= rescale(s_re);
      p.im <= rescale(s_im);
    end
  end

endmodule

// File: rtl/conj_vxc_addsub_pipe.sv
// NI-lane R = A +/- conj(c)*conj(V), fixed 3-stage pipeline.
// Build macro CONJ_VXC_SAT_EN selects saturating arithmetic.
module conj_vxc_addsub_pipe
  import conj_vxc_pkg::*;
#(
  parameter int NI = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NI*EW-1:0] first_row,
  input  logic [EW-1:0]    constant,
  input  logic [NI*EW-1:0] second_row,
  input  logic             op,
  output logic [NI*EW-1:0] result,
  output logic             finish_out
);

  logic [NI*EW-1:0] a_s1, v_s1;
  logic [NI*EW-1:0] a_s2, p_s2;
  logic [NI*EW-1:0] r_next;
  cplx_t            c_s1;
  logic             op_s1, op_s2;
  logic [1:0]       fill;

  // Stage 1: register all operands
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_s1  <= '0;
      v_s1  <= '0;
      c_s1  <= '0;
      op_s1 <= 1'b0;
    end else begin
      a_s1  <= first_row;
      v_s1  <= second_row;
      c_s1  <= constant;
      op_s1 <= op;
    end
  end

  for (genvar i = 0; i < NI; i++) begin : g_lane
    cplx_t a_l, p_l;

    conj_cmul_lane u_lane (
      .clk   (clk),
      .reset (reset),
      .c     (c_s1),
      .v     (v_s1[i*EW +: EW]),
      .p     (p_s2[i*EW +: EW])
    );

    assign a_l = a_s2[i*EW +: EW];
    assign p_l = p_s2[i*EW +: EW];
    assign r_next[i*EW +: EW] = {
      addsub(a_l.re, p_l.re, op_s2),
      addsub(a_l.im, p_l.im, op_s2)
    };
  end

  // Stage 2: carry A and op alongside the lane products
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_s2  <= '0;
      op_s2 <= 1'b0;
    end else begin
      a_s2  <= a_s1;
      op_s2 <= op_s1;
    end
  end

  // Stage 3: result register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) result <= '0;
    else       result <= r_next;
  end

  // Fill counter; finish_out rises on the LAT-th edge and stays set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill       <= '0;
      finish_out <= 1'b0;
    end else begin
      if (fill != 2'(LAT-1)) fill <= fill + 2'd1;
      finish_out <= finish_out | (fill == 2'(LAT-1));
    end
  end

endmodule

// File: tb/tb_conj_vxc_addsub_pipe.sv
// Self-checking bench for conj_vxc_addsub_pipe (honours CONJ_VXC_SAT_EN).
// Table vectors, op-latency and reset sequences, random streaming.
module tb_conj_vxc_addsub_pipe;
  import conj_vxc_pkg::*;

  localparam int NI = 8;
  localparam int W  = NI * EW;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] first_row, second_row, result;
  logic [EW-1:0] constant;
  logic         op, finish_out;

  always #5 clk = ~clk;

  conj_vxc_addsub_pipe #(.NI(NI)) dut (
    .clk        (clk),
    .reset      (reset),
    .first_row  (first_row),
    .constant   (constant),
    .second_row (second_row),
    .op         (op),
    .result     (result),
    .finish_out (finish_out)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rep(input logic [63:0] x);
    return {NI{x}};
  endfunction

  // Reference: exact integer math, floor division, then fit to 32 bits
  function automatic logic [31:0] fit(input logic signed [127:0] v);
`ifdef CONJ_VXC_SAT_EN
    if (v > 128'sd2147483647) return 32'h7FFFFFFF;
    if (v < -128'sd2147483648) return 32'h80000000;
`endif
    return v[31:0];
  endfunction

  function automatic logic signed [127:0] floor_div(
    input logic signed [127:0] s);
    logic signed [127:0] q;
    q = s / 128'sd65536;
    if (s < 0 && q * 128'sd65536 != s) q = q - 1;
    return q;
  endfunction

  function automatic logic [63:0] model(input logic [63:0] a,
    input logic [63:0] c, input logic [63:0] v, input logic sub);
    logic signed [127:0] ar, ai, cr, ci, vr, vi, pr, pi, rr, ri;
    ar = $signed(a[63:32]); ai = $signed(a[31:0]);
    cr = $signed(c[63:32]); ci = $signed(c[31:0]);
    vr = $signed(v[63:32]); vi = $signed(v[31:0]);
    pr = $signed(fit(floor_div(cr * vr - ci * vi)));
    pi = $signed(fit(floor_div(-(cr * vi + ci * vr))));
    rr = sub ? ar - pr : ar + pr;
    ri = sub ? ai - pi : ai + pi;
    return {fit(rr), fit(ri)};
  endfunction

  function automatic logic [W-1:0] model_vec(input logic [W-1:0] a,
    input logic [63:0] c, input logic [W-1:0] v, input logic sub);
    logic [W-1:0] r;
    r = '0;
    for (int l = 0; l < NI; l++)
      r[l*EW +: EW] = model(a[l*EW +: EW], c, v[l*EW +: EW], sub);
    return r;
  endfunction

  function automatic logic [31:0] rcomp();
    case ($urandom_range(0, 7))
      0:       return 32'h80000000;
      1:       return 32'h7FFFFFFF;
      2:       return 32'h00000000;
      default: return $urandom;
    endcase
  endfunction

  task automatic step(input logic [W-1:0] a, input logic [63:0] c,
                      input logic [W-1:0] v, input logic sub);
    first_row  = a;
    constant   = c;
    second_row = v;
    op         = sub;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [63:0] a;
    logic [63:0] c;
    logic [63:0] v;
    logic        sub;
    logic [63:0] exp;
  } vec_t;

  vec_t         tbl [5];
  logic [W-1:0] q_exp [$];
  logic [W-1:0] ra, rv;
  logic [63:0]  rc;
  int           since_rst;

  initial begin
    tbl[0] = '{"add", 64'h00010000_00000000, 64'h00020000_00010000,
               64'h00010000_00010000, 1'b0, 64'h00020000_FFFD0000};
    tbl[1] = '{"sub", 64'h00010000_00000000, 64'h00020000_00010000,
               64'h00010000_00010000, 1'b1, 64'h00000000_00030000};
    tbl[3] = '{"c_zero", 64'h12345678_9ABCDEF0, 64'h0,
               64'hDEADBEEF_CAFEBABE, 1'b1, 64'h12345678_9ABCDEF0};
`ifdef CONJ_VXC_SAT_EN
    tbl[2] = '{"ovf", 64'h7FFFFFFF_00000000, 64'h00010000_00000000,
               64'h00010000_00000000, 1'b0, 64'h7FFFFFFF_00000000};
    tbl[4] = '{"most_neg", 64'hFFFF0000_00000005, 64'h80000000_00000000,
               64'h00010000_00000000, 1'b0, 64'h80000000_00000005};
`else
    tbl[2] = '{"ovf", 64'h7FFFFFFF_00000000, 64'h00010000_00000000,
               64'h00010000_00000000, 1'b0, 64'h8000FFFF_00000000};
    tbl[4] = '{"most_neg", 64'hFFFF0000_00000005, 64'h80000000_00000000,
               64'h00010000_00000000, 1'b0, 64'h7FFF0000_00000005};
`endif

    reset      = 1'b1;
    first_row  = '0;
    second_row = '0;
    constant   = '0;
    op         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", result, '0);
    check("rst_finish", W'(finish_out), '0);
    #2 reset = 1'b0;

    for (int k = 1; k <= 3; k++) begin
      step('0, '0, '0, 1'b0);
      check("idle_result", result, '0);
      check($sformatf("idle_finish_e%0d", k), W'(finish_out),
            W'(k == 3));
    end

    foreach (tbl[t]) begin
      repeat (3) step(rep(tbl[t].a), tbl[t].c, rep(tbl[t].v), tbl[t].sub);
      check(tbl[t].name, result, rep(tbl[t].exp));
    end

    repeat (3) step(rep(tbl[0].a), tbl[0].c, rep(tbl[0].v), 1'b0);
    step(rep(tbl[0].a), tbl[0].c, rep(tbl[0].v), 1'b1);
    check("op_lat_e1", result, rep(tbl[0].exp));
    step(rep(tbl[0].a), tbl[0].c, rep(tbl[0].v), 1'b1);
    check("op_lat_e2", result, rep(tbl[0].exp));
    step(rep(tbl[0].a), tbl[0].c, rep(tbl[0].v), 1'b1);
    check("op_lat_e3", result, rep(tbl[1].exp));

    since_rst = 99;
    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        #2 reset = 1'b1;
        #1;
        check("mid_rst_result", result, '0);
        check("mid_rst_finish", W'(finish_out), '0);
        @(posedge clk);
        #1;
        check("mid_rst_hold", result, '0);
        #2 reset = 1'b0;
        q_exp.delete();
        since_rst = 0;
      end
      for (int l = 0; l < 2 * NI; l++) begin
        ra[l*32 +: 32] = rcomp();
        rv[l*32 +: 32] = rcomp();
      end
      rc = {rcomp(), rcomp()};
      q_exp.push_back(model_vec(ra, rc, rv, i[0]));
      step(ra, rc, rv, i[0]);
      if (since_rst < 3) begin
        since_rst++;
        check($sformatf("refill_finish_e%0d", since_rst),
              W'(finish_out), W'(since_rst == 3));
        if (since_rst < 3)
          check("refill_result", result, '0);
      end
      if (q_exp.size() == 3)
        check($sformatf("stream_%0d", i), result, q_exp.pop_front());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
